// File: rtl/usb_pkg.sv
// Types shared by usb_tx and its front-end scheduler.
package usb_pkg;

  typedef enum logic [1:0] {
    PKT_DATA0 = 2'd0,
    PKT_ACK   = 2'd1,
    PKT_NAK   = 2'd2,
    PKT_STALL = 2'd3
  } tx_packet_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LAUNCH   = 3'd1,
    WAIT_ACT = 3'd2,
    ACTIVE   = 3'd3,
    GAP      = 3'd4
  } tx_sched_state_t;

  // Width of a down-counter that must hold the larger of two cycle counts.
  function automatic int sched_cnt_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sched_timer.sv
// Loadable down-counter with zero flag; saturates at 0.
module sched_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                       cnt_d = val_i;
    else if (dec_i && cnt_q != '0)    cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/usb_tx_sched.sv
// Arbitrates handshake vs DATA0 requests into usb_tx, supervises the packet,
// and enforces an inter-packet gap.
module usb_tx_sched
  import usb_pkg::*;
#(
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hs_req,
  input  logic [1:0] hs_type,
  input  logic       data_req,
  input  logic       TX_Transfer_Active,
  input  logic       TX_Error,
  input  logic       err_clr,
  output logic       TX_Start,
  output logic [1:0] TX_Packet,
  output logic       tx_busy,
  output logic       hs_done,
  output logic       data_done,
  output logic       tx_err,
  output logic       hs_overrun
);

  localparam int CW = sched_cnt_w(GAP_CYCLES, TIMEOUT_CYCLES);

  tx_sched_state_t state_q, state_d;
  tx_packet_t      hs_type_q, pkt_q;
  logic            hs_pend_q, data_pend_q, src_hs_q;
  logic            hs_done_q, data_done_q, tx_err_q, ovr_q;
  logic            grant_hs, grant_data, err_set, done_set, hs_valid;
  logic            tmr_load, tmr_dec, tmr_zero;
  logic [CW-1:0]   tmr_val, tmr_cnt;

  assign hs_valid = hs_req && (hs_type != 2'd0);

  always_comb begin
    state_d    = state_q;
    grant_hs   = 1'b0;
    grant_data = 1'b0;
    err_set    = 1'b0;
    done_set   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hs_pend_q) begin
          state_d  = LAUNCH;
          grant_hs = 1'b1;
        end else if (data_pend_q) begin
          state_d    = LAUNCH;
          grant_data = 1'b1;
        end
      end
      LAUNCH: state_d = WAIT_ACT;
      WAIT_ACT: begin
        // Timeout fires on the cycle the count would step down to zero.
        if (TX_Error || (!TX_Transfer_Active && tmr_cnt <= CW'(1))) begin
          err_set = 1'b1;
          state_d = GAP;
        end else if (TX_Transfer_Active) begin
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (TX_Error) begin
          err_set = 1'b1;
          state_d = GAP;
        end else if (!TX_Transfer_Active) begin
          done_set = 1'b1;
          state_d  = GAP;
        end
      end
      GAP:     if (tmr_zero) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign tmr_load = (state_q == LAUNCH) || (state_d == GAP && state_q != GAP);
  assign tmr_val  = (state_q == LAUNCH) ? CW'(TIMEOUT_CYCLES) : CW'(GAP_CYCLES);
  assign tmr_dec  = (state_q == WAIT_ACT) || (state_q == GAP);

  sched_timer #(.W(CW)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i (tmr_load),
    .val_i  (tmr_val),
    .dec_i  (tmr_dec),
    .cnt_o  (tmr_cnt),
    .zero_o (tmr_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      hs_pend_q   <= 1'b0;
      hs_type_q   <= PKT_ACK;
      data_pend_q <= 1'b0;
      src_hs_q    <= 1'b0;
      pkt_q       <= PKT_DATA0;
      hs_done_q   <= 1'b0;
      data_done_q <= 1'b0;
      tx_err_q    <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      // A fresh request in the grant cycle re-pends instead of being lost.
      if (hs_valid)      hs_pend_q <= 1'b1;
      else if (grant_hs) hs_pend_q <= 1'b0;
      if (hs_valid)      hs_type_q <= tx_packet_t'(hs_type);
      if (data_req)        data_pend_q <= 1'b1;
      else if (grant_data) data_pend_q <= 1'b0;
      if (grant_hs || grant_data) begin
        src_hs_q <= grant_hs;
        pkt_q    <= grant_hs ? hs_type_q : PKT_DATA0;
      end
      hs_done_q   <= done_set && src_hs_q;
      data_done_q <= done_set && !src_hs_q;
      if (err_set || (hs_req && hs_type == 2'd0)) tx_err_q <= 1'b1;
      else if (err_clr)                           tx_err_q <= 1'b0;
      if (hs_valid && hs_pend_q && !grant_hs) ovr_q <= 1'b1;
      else if (err_clr)                       ovr_q <= 1'b0;
    end
  end

  assign TX_Start   = (state_q == LAUNCH);
  assign TX_Packet  = pkt_q;
  assign tx_busy    = (state_q != IDLE);
  assign hs_done    = hs_done_q;
  assign data_done  = data_done_q;
  assign tx_err     = tx_err_q;
  assign hs_overrun = ovr_q;

endmodule
